// File: rtl/fpdiv_if.sv
// -----------------------------------------------------------------------------
// fpdiv_if : request/result bundle of the sequential FP divider.
//   Start  request, sampled by the divider only while it is idle
//   A, B   dividend / divisor (IEEE-754 single precision)
//   Done   one-cycle completion pulse
//   Q      quotient, held until the next result is packed
//   OF UF NaNF InfF DNF ZF DZF  result status flags
// master drives the request, slave (the divider) drives the result.
// -----------------------------------------------------------------------------
interface fpdiv_if;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Done;
  logic [31:0] Q;
  logic        OF;
  logic        UF;
  logic        NaNF;
  logic        InfF;
  logic        DNF;
  logic        ZF;
  logic        DZF;

  modport master (output Start, A, B,
                  input  Done, Q, OF, UF, NaNF, InfF, DNF, ZF, DZF);
  modport slave  (input  Start, A, B,
                  output Done, Q, OF, UF, NaNF, InfF, DNF, ZF, DZF);
endinterface

// File: rtl/fpdiv_seq.sv
// -----------------------------------------------------------------------------
// fpdiv_seq : sequential IEEE-754 single-precision divider, Q = A / B.
// Restoring mantissa divider producing one quotient bit per cycle,
// round-to-nearest-even, denormal inputs flushed to zero, no denormal output.
// Ports:
//   Clk   clock, all state changes on the rising edge
//   Rst   synchronous active-high reset, abandons any divide in progress
//   bus   fpdiv_if.slave : Start/A/B request in, Done/Q/flags result out
// -----------------------------------------------------------------------------
module fpdiv_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int unsigned ITER = 26
) (
  input  logic   Clk,
  input  logic   Rst,
  fpdiv_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIV, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  // special-operand outcome decided in CHECK, consumed in PACK
  typedef enum logic [1:0] {K_NONE, K_NAN, K_INF, K_ZERO} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [25:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [23:0]        mant_q, mant_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               dnf_q, dnf_d;
  logic               dzf_q, dzf_d;
  logic               done_q, done_d;
  logic [31:0]        qout_q, qout_d;
  // flag order: {OF, UF, NaNF, InfF, DNF, ZF, DZF}
  logic [6:0]         flags_q, flags_d;

  // operand field decode of the captured operands
  logic [7:0]  ea_s, eb_s;
  logic [22:0] fa_s, fb_s;
  logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic        ge_s;
  logic [24:0] diff_s;
  logic [24:0] inc_s;

  assign ea_s     = a_q[30:23];
  assign eb_s     = b_q[30:23];
  assign fa_s     = a_q[22:0];
  assign fb_s     = b_q[22:0];
  // exponent field 0 is zero whatever the fraction (denormals flushed)
  assign a_zero_s = (ea_s == 8'h00);
  assign b_zero_s = (eb_s == 8'h00);
  assign a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
  assign b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
  assign a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
  assign b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);

  // one restoring step: subtract the divisor when it fits
  assign ge_s   = (rem_q >= {1'b0, mb_q});
  assign diff_s = ge_s ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign inc_s  = {1'b0, mant_q} + 25'd1;

  // next-state and datapath update for every FSM state
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    dnf_d    = dnf_q;
    dzf_d    = dzf_q;
    qout_d   = qout_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CHECK: begin
        sign_d = a_q[31] ^ b_q[31];
        exp_d  = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
        rem_d  = {2'b01, fa_s};
        mb_d   = {1'b1, fb_s};
        quo_d  = 26'd0;
        cnt_d  = 5'd0;
        dnf_d  = (a_zero_s && (fa_s != 23'd0)) || (b_zero_s && (fb_s != 23'd0));
        dzf_d  = 1'b0;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
          kind_d = K_NAN;
        end else if (a_inf_s || b_zero_s) begin
          kind_d = K_INF;
          dzf_d  = b_zero_s && !a_inf_s && !a_zero_s;
        end else if (a_zero_s || b_inf_s) begin
          kind_d = K_ZERO;
        end else begin
          kind_d = K_NONE;
        end
        state_d = (kind_d == K_NONE) ? S_DIV : S_PACK;
      end

      S_DIV: begin
        // diff_s < divisor < 2^24, so dropping bit 24 on the shift loses nothing
        rem_d = {diff_s[23:0], 1'b0};
        quo_d = {quo_q[24:0], ge_s};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = S_NORM;
        end else begin
          state_d = S_DIV;
        end
      end

      S_NORM: begin
        if (quo_q[25]) begin
          mant_d   = quo_q[25:2];
          guard_d  = quo_q[1];
          sticky_d = (|rem_q) | quo_q[0];
        end else begin
          mant_d   = quo_q[24:1];
          guard_d  = quo_q[0];
          sticky_d = |rem_q;
          exp_d    = exp_q - 10'sd1;
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        if (guard_q && (sticky_q || mant_q[0])) begin
          if (inc_s[24]) begin
            mant_d = 24'h80_0000;
            exp_d  = exp_q + 10'sd1;
          end else begin
            mant_d = inc_s[23:0];
          end
        end else begin
          mant_d = mant_q;
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        flags_d = {4'b0000, dnf_q, 2'b00};
        case (kind_q)
          K_NAN: begin
            qout_d     = QNAN;
            flags_d[4] = 1'b1;
          end
          K_INF: begin
            qout_d     = {sign_q, 8'hFF, 23'd0};
            flags_d[3] = 1'b1;
            flags_d[0] = dzf_q;
          end
          K_ZERO: begin
            qout_d     = {sign_q, 31'd0};
            flags_d[1] = 1'b1;
          end
          default: begin
            if (exp_q >= 10'sd255) begin
              qout_d     = {sign_q, 8'hFF, 23'd0};
              flags_d[6] = 1'b1;
              flags_d[3] = 1'b1;
            end else if (exp_q <= 10'sd0) begin
              qout_d     = {sign_q, 31'd0};
              flags_d[5] = 1'b1;
              flags_d[1] = 1'b1;
            end else begin
              qout_d = {sign_q, exp_q[7:0], mant_q[22:0]};
            end
          end
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Done is registered so that it is high exactly while in DONE
    done_d = (state_d == S_DONE);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mb_q     <= 24'd0;
      rem_q    <= 25'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
      mant_q   <= 24'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      dnf_q    <= 1'b0;
      dzf_q    <= 1'b0;
      done_q   <= 1'b0;
      qout_q   <= 32'd0;
      flags_q  <= 7'd0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      dnf_q    <= dnf_d;
      dzf_q    <= dzf_d;
      done_q   <= done_d;
      qout_q   <= qout_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.Done = done_q;
  assign bus.Q    = qout_q;
  assign bus.OF   = flags_q[6];
  assign bus.UF   = flags_q[5];
  assign bus.NaNF = flags_q[4];
  assign bus.InfF = flags_q[3];
  assign bus.DNF  = flags_q[2];
  assign bus.ZF   = flags_q[1];
  assign bus.DZF  = flags_q[0];

endmodule

// File: tb/tb_fpdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_fpdiv_seq : self-checking bench for fpdiv_seq.
// Directed vectors, randomized operands against an arithmetic reference model,
// and handshake/protocol scenarios (held Start, mid-divide reset, back-to-back).
// -----------------------------------------------------------------------------
module tb_fpdiv_seq;

  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  fpdiv_if bus();

  fpdiv_seq dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // flag vector order: {OF, UF, NaNF, InfF, DNF, ZF, DZF}
  function automatic logic [6:0] dut_flags();
    return {bus.OF, bus.UF, bus.NaNF, bus.InfF, bus.DNF, bus.ZF, bus.DZF};
  endfunction

  // Reference: exact quotient by integer division, then round-to-nearest-even.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [6:0] f, output bit sp);
    int ea, eb, e;
    logic [22:0] fa, fb;
    logic s;
    bit az, bz, ai, bi, an, bn, g, st;
    longint unsigned ma, mb, num, quo, rem, mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (fa == 23'd0);
    bi = (eb == 255) && (fb == 23'd0);
    an = (ea == 255) && (fa != 23'd0);
    bn = (eb == 255) && (fb != 23'd0);
    f  = 7'd0;
    f[2] = (az && fa != 23'd0) || (bz && fb != 23'd0);
    sp = 1'b1;
    q  = 32'd0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      q = 32'h7FC0_0000; f[4] = 1'b1;
    end else if (ai || bz) begin
      q = {s, 8'hFF, 23'd0}; f[3] = 1'b1; f[0] = bz && !ai && !az;
    end else if (az || bi) begin
      q = {s, 31'd0}; f[1] = 1'b1;
    end else begin
      sp  = 1'b0;
      e   = ea - eb + 127;
      ma  = 64'h80_0000 | 64'(fa);
      mb  = 64'h80_0000 | 64'(fb);
      num = ma << 25;
      quo = num / mb;
      rem = num % mb;
      if (quo >= (64'd1 << 25)) begin
        mant = quo >> 2; g = quo[1]; st = quo[0] || (rem != 64'd0);
      end else begin
        mant = quo >> 1; g = quo[0]; st = (rem != 64'd0); e = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
        mant = mant >> 1; e = e + 1;
      end
      if (e >= 255) begin
        q = {s, 8'hFF, 23'd0}; f[6] = 1'b1; f[3] = 1'b1;
      end else if (e <= 0) begin
        q = {s, 31'd0}; f[5] = 1'b1; f[1] = 1'b1;
      end else begin
        q = {s, e[7:0], mant[22:0]};
      end
    end
  endtask

  function automatic logic [31:0] gen_operand();
    logic [31:0] specials [7];
    int r;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001};
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      return specials[$urandom_range(0, 6)];
    end else if (r == 1) begin
      return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 4)), 23'($urandom)};
    end else if (r == 2) begin
      return {1'($urandom_range(0, 1)), 8'($urandom_range(250, 254)), 23'($urandom)};
    end else begin
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    end
  endfunction

  // present a request for one edge; caller must be in an IDLE cycle
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
  endtask

  // edges counted from the accepting edge until Done is seen; -1 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!bus.Done && lat < 60);
    if (!bus.Done) lat = -1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.Start = 1'b1;
    bus.A = 32'h40C0_0000;
    bus.B = 32'h4000_0000;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    total++;
    if (bus.Q !== 32'd0) begin bad++; $display("FAIL reset_q got=%h exp=00000000", bus.Q); end
    total++;
    if (dut_flags() !== 7'd0) begin bad++; $display("FAIL reset_flags got=%b exp=0000000", dut_flags()); end
    Rst = 1'b0;
    bus.Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (bus.Done !== 1'b0 || bus.Q !== 32'd0) begin
      bad++; $display("FAIL post_reset_idle done=%b q=%h exp done=0 q=0", bus.Done, bus.Q);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [31:0] vq [10];
    logic [6:0]  vf [10];
    int          vl [10];
    int lat;
    va = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F00_0000,
           32'h0080_0000, 32'h0000_0001, 32'hBF80_0000, 32'h7FC0_0001, 32'h7F80_0000};
    vb = '{32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000, 32'h3E80_0000,
           32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
    vq = '{32'h4040_0000, 32'h3EAA_AAAB, 32'h7F80_0000, 32'h7FC0_0000, 32'h7F80_0000,
           32'h0000_0000, 32'h0000_0000, 32'hBF00_0000, 32'h7FC0_0000, 32'h7F80_0000};
    vf = '{7'b0000000, 7'b0000000, 7'b0001001, 7'b0010000, 7'b1001000,
           7'b0100010, 7'b0000110, 7'b0000000, 7'b0010000, 7'b0001000};
    vl = '{30, 30, 2, 2, 30, 30, 2, 30, 2, 2};
    for (int i = 0; i < 10; i++) begin
      launch(va[i], vb[i]);
      wait_done(lat);
      total++;
      if (lat !== vl[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
      total++;
      if (bus.Q !== vq[i]) begin bad++; $display("FAIL dir%0d_q got=%h exp=%h", i, bus.Q, vq[i]); end
      total++;
      if (dut_flags() !== vf[i]) begin bad++; $display("FAIL dir%0d_flags got=%b exp=%b", i, dut_flags(), vf[i]); end
      @(posedge Clk); #1;
      total++;
      if (bus.Done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width got=%b exp=0", i, bus.Done); end
      total++;
      if (bus.Q !== vq[i]) begin bad++; $display("FAIL dir%0d_q_hold got=%h exp=%h", i, bus.Q, vq[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq;
    logic [6:0]  ef;
    bit sp;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = gen_operand();
      b = gen_operand();
      ref_div(a, b, eq, ef, sp);
      launch(a, b);
      wait_done(lat);
      total++;
      if (lat !== (sp ? 2 : 30)) begin bad++; $display("FAIL rnd_latency a=%h b=%h got=%0d exp=%0d", a, b, lat, sp ? 2 : 30); end
      total++;
      if (bus.Q !== eq) begin bad++; $display("FAIL rnd_q a=%h b=%h got=%h exp=%h", a, b, bus.Q, eq); end
      total++;
      if (dut_flags() !== ef) begin bad++; $display("FAIL rnd_flags a=%h b=%h got=%b exp=%b", a, b, dut_flags(), ef); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_start_hold();
    int lat;
    launch(32'h40C0_0000, 32'h4000_0000);
    // keep requesting a different divide while the first one runs
    bus.Start = 1'b1;
    bus.A = 32'h3F80_0000;
    bus.B = 32'h4040_0000;
    wait_done(lat);
    bus.Start = 1'b0;
    total++;
    if (lat !== 30) begin bad++; $display("FAIL hold_latency got=%0d exp=30", lat); end
    total++;
    if (bus.Q !== 32'h4040_0000) begin bad++; $display("FAIL hold_q got=%h exp=40400000", bus.Q); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_div();
    int lat;
    bit seen;
    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (10) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.Done) seen = 1'b1;
      @(posedge Clk); #1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rstdiv_no_done got=%b exp=0", seen); end
    total++;
    if (bus.Q !== 32'd0 || dut_flags() !== 7'd0) begin
      bad++; $display("FAIL rstdiv_cleared q=%h flags=%b exp q=00000000 flags=0000000", bus.Q, dut_flags());
    end
    launch(32'h40C0_0000, 32'h4000_0000);
    wait_done(lat);
    total++;
    if (lat !== 30 || bus.Q !== 32'h4040_0000) begin
      bad++; $display("FAIL rstdiv_fresh lat=%0d q=%h exp lat=30 q=40400000", lat, bus.Q);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, eq1, eq2;
    logic [6:0]  ef1, ef2;
    bit sp1, sp2;
    int lat;
    a1 = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
    b1 = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
    a2 = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
    b2 = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
    ref_div(a1, b1, eq1, ef1, sp1);
    ref_div(a2, b2, eq2, ef2, sp2);
    launch(a1, b1);
    wait_done(lat);
    total++;
    if (bus.Q !== eq1 || dut_flags() !== ef1) begin
      bad++; $display("FAIL b2b_first q=%h flags=%b exp q=%h flags=%b", bus.Q, dut_flags(), eq1, ef1);
    end
    // Start raised in the DONE cycle: ignored there, accepted in the next IDLE cycle
    bus.Start = 1'b1;
    bus.A = a2;
    bus.B = b2;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    wait_done(lat);
    total++;
    if (lat !== (sp2 ? 2 : 30)) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, sp2 ? 2 : 30); end
    total++;
    if (bus.Q !== eq2 || dut_flags() !== ef2) begin
      bad++; $display("FAIL b2b_second q=%h flags=%b exp q=%h flags=%b", bus.Q, dut_flags(), eq2, ef2);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b1;
    bus.Start = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_start_hold();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
